commit_trace_buffer: RTL

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

---
 rtl/commit_trace_buffer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: FIFO of retired-instruction records with numbering, drop/overflow and halt tracking
// Inputs: clk, rst (sync, active-high), in_valid + in_* retire record fields, out_ready.
// Outputs: out_valid + out_* head record fields, inst_count, dropped_count, overflow, halted, empty, full.
// Optional: define COMMIT_TRACE_CYCLE_STAMP_EN to add out_cycle, a per-entry free-running cycle stamp.
module commit_trace_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_pc,
  input  logic        in_reg_write,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_halt,
  input  logic [2:0]  in_write_reg,
  input  logic [15:0] in_write_data,
  input  logic [15:0] in_mem_addr,
  input  logic [15:0] in_mem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inum,
  output logic [15:0] out_pc,
  output logic [3:0]  out_flags,
  output logic [2:0]  out_write_reg,
  output logic [15:0] out_write_data,
  output logic [15:0] out_mem_addr,
  output logic [15:0] out_mem_data,
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
  output logic [31:0] out_cycle,
`endif
  output logic [31:0] inst_count,
  output logic [15:0] dropped_count,
  output logic        overflow,
  output logic        halted,
  output logic        empty,
  output logic        full
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [31:0] inum;
    logic [15:0] pc;
    logic [3:0]  flags;
    logic [2:0]  wreg;
    logic [15:0] wdata;
    logic [15:0] maddr;
    logic [15:0] mdata;
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    logic [31:0] cyc;
`endif
  } entry_t;
  entry_t mem_q [DEPTH];
  entry_t in_entry, head;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d;
  logic [15:0] drop_q, drop_d;
  logic ovf_q, ovf_d, halt_q, halt_d;
  logic push, pop, store, drop;
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
  logic [31:0] cyc_q;
`endif
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign out_valid = ~empty;
  assign push = in_valid & ~halt_q;
  assign pop = out_valid & out_ready;
  // a pop in the same cycle frees the slot, so a full FIFO only drops without one
  assign store = push & (~full | pop);
  assign drop = push & full & ~pop;
  always_comb begin
    in_entry = '0;
    in_entry.inum = inst_q;
    in_entry.pc = in_pc;
    in_entry.flags = {in_halt, in_mem_write, in_mem_read, in_reg_write};
    in_entry.wreg = in_write_reg;
    in_entry.wdata = in_write_data;
    in_entry.maddr = in_mem_addr;
    in_entry.mdata = in_mem_data;
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    in_entry.cyc = cyc_q;
`endif
    wr_d = store ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + {{AW{1'b0}}, store} - {{AW{1'b0}}, pop};
    inst_d = push ? inst_q + 32'd1 : inst_q;
    drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    ovf_d = ovf_q | drop;
    halt_d = halt_q | (push & in_halt);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      inst_q <= '0;
      drop_q <= '0;
      ovf_q <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      inst_q <= inst_d;
      drop_q <= drop_d;
      ovf_q <= ovf_d;
      halt_q <= halt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && store) mem_q[wr_q] <= in_entry;
  end
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
  always_ff @(posedge clk) begin
    if (rst) cyc_q <= '0;
    else cyc_q <= cyc_q + 32'd1;
  end
  assign out_cycle = head.cyc;
`endif
  assign head = mem_q[rd_q];
  assign out_inum = head.inum;
  assign out_pc = head.pc;
  assign out_flags = head.flags;
  assign out_write_reg = head.wreg;
  assign out_write_data = head.wdata;
  assign out_mem_addr = head.maddr;
  assign out_mem_data = head.mdata;
  assign inst_count = inst_q;
  assign dropped_count = drop_q;
  assign overflow = ovf_q;
  assign halted = halt_q;
endmodule
